// File: rtl/floating_point_stream_buffer.sv
// floating_point_stream_buffer
//   Show-ahead FIFO for floating-point words coming from a valid-only
//   upstream pipeline. The upstream cannot be stalled. The word stream passes
//   through one registered input stage and is then written into a circular
//   storage array. A word that arrives when the buffer is full and nothing is
//   popped is dropped, and the sticky overflow flag is set.
//
//   Optional feature: when the macro FP_STREAM_BUFFER_DROP_CNT_EN is defined,
//   drop_count_o counts dropped words and saturates at 16'hFFFF. When the
//   macro is not defined, drop_count_o is tied to zero.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset
//   fp_a_i         incoming word (sign | exponent | fraction)
//   valid_i        fp_a_i qualifier
//   fp_o           head-of-buffer word, valid while valid_o=1
//   valid_o        buffer non-empty
//   ready_i        downstream accept; a pop happens when valid_o && ready_i
//   almost_full_o  count_o >= DEPTH - AF_MARGIN
//   overflow_o     sticky: a word was dropped since reset
//   count_o        current occupancy, 0..DEPTH
//   drop_count_o   dropped-word counter (zero unless the macro is defined)

module floating_point_stream_buffer #(
  parameter int EXP_WIDTH  = 0,
  parameter int FRAC_WIDTH = 0,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 3,
  localparam int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] fp_a_i,
  input  logic                    valid_i,
  output logic [FP_WIDTH_REG-1:0] fp_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    almost_full_o,
  output logic                    overflow_o,
  output logic [CNT_W-1:0]        count_o,
  output logic [15:0]             drop_count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [FP_WIDTH_REG-1:0] in_data_q, in_data_d;
  logic                    in_valid_q, in_valid_d;
  logic [FP_WIDTH_REG-1:0] mem_q [DEPTH];
  logic [FP_WIDTH_REG-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;

  logic pop;
  logic push;
  logic drop;

  // A pop frees a slot in the same cycle, so a full buffer can still accept
  // a push. Occupancy comes from count_q. Pointer equality alone cannot tell
  // full from empty.
  assign pop  = (count_q != '0) && ready_i;
  assign push = in_valid_q && ((count_q != DEPTH_C) || pop);
  assign drop = in_valid_q && !push;

  always_comb begin
    in_data_d  = fp_a_i;
    in_valid_d = valid_i;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    if (push) begin
      mem_d[wr_ptr_q] = in_data_q;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Data-path registers carry no reset. Stale contents are never visible
  // because valid_o follows the occupancy count.
  always_ff @(posedge clk_i) begin
    in_data_q <= in_data_d;
    mem_q     <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      in_valid_q <= in_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign fp_o          = mem_q[rd_ptr_q];
  assign valid_o       = (count_q != '0);
  assign almost_full_o = (count_q >= AF_THRESH);
  assign overflow_o    = overflow_q;
  assign count_o       = count_q;

`ifdef FP_STREAM_BUFFER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_floating_point_stream_buffer.sv
// Directed bench for floating_point_stream_buffer with EXP_WIDTH=8,
// FRAC_WIDTH=23, DEPTH=8 and AF_MARGIN=3.
// Inputs are driven 1 ns after a rising edge and outputs are sampled at the
// same point. "Edge 0" is the edge after which a word is first driven. The
// input stage captures that word at edge 1, and storage holds it after edge 2.

module tb_floating_point_stream_buffer;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int DEPTH  = 8;
  localparam int AF_M   = 3;

`ifdef FP_STREAM_BUFFER_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd2;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] fp_a_i;
  logic        valid_i;
  logic [31:0] fp_o;
  logic        valid_o;
  logic        ready_i;
  logic        almost_full_o;
  logic        overflow_o;
  logic [3:0]  count_o;
  logic [15:0] drop_count_o;

  int checks = 0;
  int errors = 0;

  floating_point_stream_buffer #(
    .EXP_WIDTH (EXP_W),
    .FRAC_WIDTH(FRAC_W),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_M)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fp_a_i       (fp_a_i),
    .valid_i      (valid_i),
    .fp_o         (fp_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .almost_full_o(almost_full_o),
    .overflow_o   (overflow_o),
    .count_o      (count_o),
    .drop_count_o (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    fp_a_i  = 32'h0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    fp_a_i  = 32'h0;
    tick();
    tick();
    rst_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow_o); end
    checks++; if (drop_count_o !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count_o); end
  endtask

  task automatic test_latency();
    ready_i = 1'b1;
    valid_i = 1'b1;
    fp_a_i  = 32'h3F80_0000;
    tick();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lat_valid_e1 got %b exp 0", valid_o); end
    tick();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL lat_valid_e2 got %b exp 1", valid_o); end
    checks++; if (fp_o !== 32'h3F80_0000) begin errors++; $display("FAIL lat_data_e2 got %h exp 3f800000", fp_o); end
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL lat_count_e2 got %0d exp 1", count_o); end
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL lat_count_e3 got %0d exp 0", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lat_valid_e3 got %b exp 0", valid_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_order_af();
    ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      valid_i = 1'b1;
      fp_a_i  = 32'(i);
      tick();
    end
    valid_i = 1'b0;
    checks++; if (count_o !== 4'd4) begin errors++; $display("FAIL af_count4 got %0d exp 4", count_o); end
    checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL af_at4 got %b exp 0", almost_full_o); end
    tick();
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL af_count5 got %0d exp 5", count_o); end
    checks++; if (almost_full_o !== 1'b1) begin errors++; $display("FAIL af_at5 got %b exp 1", almost_full_o); end
    ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      checks++; if (fp_o !== 32'(i)) begin errors++; $display("FAIL order_pop%0d got %h exp %h", i, fp_o, 32'(i)); end
      tick();
    end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL order_empty got %b exp 0", valid_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      valid_i = 1'b1;
      fp_a_i  = 32'hA000_0000 | 32'(i);
      tick();
    end
    valid_i = 1'b0;
    tick();
    tick();
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", count_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow_o); end
    checks++; if (drop_count_o !== EXP_DROP) begin errors++; $display("FAIL ovf_drops got %0d exp %0d", drop_count_o, EXP_DROP); end
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (fp_o !== (32'hA000_0000 | 32'(i))) begin errors++; $display("FAIL ovf_pop%0d got %h exp %h", i, fp_o, 32'hA000_0000 | 32'(i)); end
      tick();
    end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovf_lost got %b exp 0", valid_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    int exp_head;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      valid_i = 1'b1;
      fp_a_i  = 32'hC000_0000 | 32'(i);
      tick();
    end
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL fpp_fill got %0d exp 8", count_o); end
    exp_head = 1;
    for (int i = 10; i <= 21; i++) begin
      ready_i = 1'b1;
      valid_i = 1'b1;
      fp_a_i  = 32'hC000_0000 | 32'(i);
      checks++; if (fp_o !== (32'hC000_0000 | 32'(exp_head))) begin errors++; $display("FAIL fpp_head%0d got %h exp %h", exp_head, fp_o, 32'hC000_0000 | 32'(exp_head)); end
      checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL fpp_count got %0d exp 8", count_o); end
      exp_head++;
      tick();
    end
    valid_i = 1'b0;
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", overflow_o); end
    for (int k = 0; k < 9; k++) begin
      checks++; if (fp_o !== (32'hC000_0000 | 32'(exp_head))) begin errors++; $display("FAIL fpp_drain%0d got %h exp %h", exp_head, fp_o, 32'hC000_0000 | 32'(exp_head)); end
      exp_head++;
      tick();
    end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL fpp_empty got %0d exp 0", count_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      valid_i = 1'b1;
      fp_a_i  = 32'h1000_0000 | 32'(i);
      tick();
    end
    checks++; if (count_o !== 4'd6) begin errors++; $display("FAIL rmid_pre got %0d exp 6", count_o); end
    rst_i  = 1'b1;
    fp_a_i = 32'hDEAD_BEEF;
    tick();
    rst_i   = 1'b0;
    valid_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", valid_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b exp 0", overflow_o); end
    tick();
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL rmid_nostore got %0d exp 0", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_nostore_v got %b exp 0", valid_o); end
  endtask

  task automatic test_stall();
    do_reset();
    valid_i = 1'b1;
    fp_a_i  = 32'h4049_0FDB;
    tick();
    fp_a_i  = 32'hC020_0000;
    tick();
    valid_i = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (fp_o !== 32'h4049_0FDB) begin errors++; $display("FAIL stall_data%0d got %h exp 40490fdb", k, fp_o); end
      checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL stall_count%0d got %0d exp 2", k, count_o); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b exp 1", k, valid_o); end
      tick();
    end
    ready_i = 1'b1;
    checks++; if (fp_o !== 32'h4049_0FDB) begin errors++; $display("FAIL stall_pop1 got %h exp 40490fdb", fp_o); end
    tick();
    checks++; if (fp_o !== 32'hC020_0000) begin errors++; $display("FAIL stall_pop2 got %h exp c0200000", fp_o); end
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL stall_empty got %0d exp 0", count_o); end
    ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_order_af();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/floating_point_stream_buffer.md
FLOATING_POINT_STREAM_BUFFER -- requirements
Module: floating_point_stream_buffer

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 0, exponent field width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 0, fraction field width.
REQ-003 SHALL have parameter DEPTH, default 8, storage entries; power of two, >= 2.
REQ-004 SHALL have parameter AF_MARGIN, default 3, free-slot margin for almost_full_o; range 0..DEPTH-1.
REQ-005 SHALL have local parameter FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH.
REQ-006 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port fp_a_i  input  FP_WIDTH_REG  word from an upstream valid-only (no backpressure) pipeline.
REQ-009 SHALL have port valid_i  input  1  fp_a_i qualifier.
REQ-010 SHALL have port fp_o  output  FP_WIDTH_REG  head-of-buffer word.
REQ-011 SHALL have port valid_o  output  1  buffer non-empty.
REQ-012 SHALL have port ready_i  input  1  downstream accept; a pop occurs when valid_o && ready_i.
REQ-013 SHALL have port almost_full_o  output  1  upstream issue-stop hint.
REQ-014 SHALL have port overflow_o  output  1  sticky, a word was dropped.
REQ-015 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port drop_count_o  output  16  dropped-word counter (see Configuration).

Function
REQ-017 SHALL register fp_a_i unconditionally and valid_i (reset-cleared) into one input stage before storage.
REQ-018 SHALL push the registered word when registered valid is 1 and (count < DEPTH or a pop occurs that cycle).
REQ-019 SHALL, for an input sampled on edge N into an empty buffer, present valid_o=1 and fp_o equal to that word after edge N+2 (2-cycle latency).
REQ-020 SHALL drive fp_o from the storage head (show-ahead); fp_o SHALL remain stable while valid_o=1 and ready_i=0.
REQ-021 SHALL deliver words in arrival order, no duplication or loss except overflow drops.
REQ-022 SHALL, when full and pushing with simultaneous pop, perform both; count unchanged.
REQ-023 SHALL, when empty, ignore ready_i; push with ready_i=1 just increments count.
REQ-024 SHALL, when full with registered valid=1 and no pop, discard the word, leave storage/count unchanged, set overflow_o.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; full/empty distinguished by count, not pointer equality alone.
REQ-026 SHALL assert almost_full_o combinationally from count_o: 1 iff count_o >= DEPTH - AF_MARGIN.
REQ-027 SHALL hold overflow_o at 1 until reset once set.

Reset
REQ-028 SHALL, on rst_i=1 at a clock edge, clear input-stage valid, pointers, count_o=0, valid_o=0, almost_full_o=0 (when AF_MARGIN<DEPTH), overflow_o=0, drop_count_o=0.
REQ-029 SHALL discard all stored and in-flight words on reset mid-operation; no pop or push in the reset cycle; fp_o value is don't-care while valid_o=0.

Configuration
REQ-030 SHALL, with macro FP_STREAM_BUFFER_DROP_CNT_EN defined, increment drop_count_o by 1 per discarded word, saturating at 16'hFFFF.
REQ-031 SHALL, without FP_STREAM_BUFFER_DROP_CNT_EN, tie drop_count_o to 0 with no counter logic; all other behaviour identical.

Verification (EXP_WIDTH=8, FRAC_WIDTH=23, DEPTH=8, AF_MARGIN=3)
REQ-032 SHALL cover latency: empty, ready_i=1, single valid_i word 32'h3F800000 at edge 0 -> valid_o=1, fp_o=32'h3F800000 after edge 2, count_o returns to 0 after edge 3.
REQ-033 SHALL cover ordering/almost_full: ready_i=0, push 32'h00000001..32'h00000005 on consecutive edges -> almost_full_o rises when count_o=5; ready_i=1 then pops 1..5 in order.
REQ-034 SHALL cover overflow: ready_i=0, push 10 words -> count_o=8, overflow_o=1, words 9 and 10 lost, drop_count_o=2 with macro, 0 without.
REQ-035 SHALL cover full push+pop: full buffer, ready_i=1 with continuous valid_i -> count_o stays 8, overflow_o stays 0, output order preserved across pointer wrap.
REQ-036 SHALL cover reset mid-operation: count_o=6, rst_i pulsed 1 cycle while valid_i=1 -> count_o=0, valid_o=0, overflow_o=0; word presented with rst_i not stored.
REQ-037 SHALL cover backpressure stall: valid_o=1, ready_i=0 for 4 cycles -> fp_o constant, count_o unchanged absent pushes.
